// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous data memory.
// Round-robin between cpu (0) and loader/debug (1), with a bounded lock
// that lets one requester take back-to-back grants.
module mem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_LOCK = 8,
    parameter int unsigned CW       = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          we0,
    input  logic          we1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {StUnlocked, StLocked} lock_state_e;

    localparam logic [CW-1:0] LockMax = CW'(MAX_LOCK);
    // A limit of one would release on the very grant that takes the lock,
    // so the lock never actually engages.
    localparam bit CanLock = (MAX_LOCK > 1);

    lock_state_e   lock_state;
    logic          lock_own;
    logic          prio;
    logic [CW-1:0] lock_cnt;
    logic [1:0]    rv;

    logic          gnt_any;
    logic          gnt_id;
    logic          gnt_we;
    logic          gnt_lock;
    logic          own_req;
    logic          own_lock;
    logic [CW-1:0] lock_cnt_inc;

    assign own_req      = lock_own ? req1 : req0;
    assign own_lock     = lock_own ? lock1 : lock0;
    assign lock_cnt_inc = lock_cnt + CW'(1);

    // Grant selection: active lock owner first, then a lone requester,
    // then the prio holder on a tie.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (lock_state == StLocked && own_req) begin
            gnt_any = 1'b1;
            gnt_id  = lock_own;
        end else if (req0 && req1) begin
            gnt_any = 1'b1;
            gnt_id  = prio;
        end else if (req0) begin
            gnt_any = 1'b1;
            gnt_id  = 1'b0;
        end else if (req1) begin
            gnt_any = 1'b1;
            gnt_id  = 1'b1;
        end
    end

    assign gnt_we   = gnt_id ? we1 : we0;
    assign gnt_lock = gnt_id ? lock1 : lock0;

    // Reset masks every strobe combinationally so nothing leaks out while held.
    assign gnt0      = ~reset & gnt_any & ~gnt_id;
    assign gnt1      = ~reset & gnt_any & gnt_id;
    assign mem_en    = ~reset & gnt_any;
    assign mem_we    = mem_en & gnt_we;
    assign mem_addr  = gnt_id ? addr1 : addr0;
    assign mem_wdata = gnt_id ? wdata1 : wdata0;
    assign rdata     = mem_rdata;
    assign rvalid0   = rv[0] & ~reset;
    assign rvalid1   = rv[1] & ~reset;

    // Round-robin pointer, read-return flags and lock FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_state <= StUnlocked;
            lock_own   <= 1'b0;
            lock_cnt   <= '0;
            prio       <= 1'b0;
            rv         <= 2'b00;
        end else begin
            if (gnt_any) begin
                prio <= ~gnt_id;
            end

            rv <= 2'b00;
            if (gnt_any && !gnt_we) begin
                rv[gnt_id] <= 1'b1;
            end

            unique case (lock_state)
                StUnlocked: begin
                    if (CanLock && gnt_any && gnt_lock) begin
                        lock_state <= StLocked;
                        lock_own   <= gnt_id;
                        lock_cnt   <= CW'(1);
                    end
                end
                StLocked: begin
                    // Owner gone, owner let go, or this grant hits the limit.
                    if (!own_req || !own_lock || lock_cnt_inc >= LockMax) begin
                        lock_state <= StUnlocked;
                        lock_cnt   <= '0;
                    end else begin
                        lock_cnt <= lock_cnt_inc;
                    end
                end
                default: begin
                    lock_state <= StUnlocked;
                    lock_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (MAX_LOCK=4) with a behavioural memory
// and a scoreboard of expected read returns.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, lock0, lock1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    typedef struct packed {
        logic [1:0]    rv;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [DW-1:0] mem [0:255];

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(4), .CW(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 32'h0000_00FF : {16'hC0DE, 8'h00, a};
    endfunction

    // 1-cycle read latency memory
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic l0, input logic w0, input logic [7:0] a0,
                         input logic r1, input logic l1, input logic w1, input logic [7:0] a1);
        req0 = r0; lock0 = l0; we0 = w0; addr0 = {24'h0, a0};
        req1 = r1; lock1 = l1; we1 = w1; addr1 = {24'h0, a1};
    endtask

    // Called just after a negedge with inputs already driven; eg = expected {gnt1,gnt0}.
    task automatic tick(input logic [1:0] eg);
        exp_t e;
        exp_t n;
        logic sel;
        #1;
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        if (reset) e.rv = 2'b00;
        check_eq("rvalid0", {31'b0, rvalid0}, {31'b0, e.rv[0]});
        check_eq("rvalid1", {31'b0, rvalid1}, {31'b0, e.rv[1]});
        if (e.rv != 2'b00) check_eq("rdata", rdata, e.data);
        check_eq("gnt0", {31'b0, gnt0}, {31'b0, eg[0]});
        check_eq("gnt1", {31'b0, gnt1}, {31'b0, eg[1]});
        check_eq("mem_en", {31'b0, mem_en}, {31'b0, |eg});
        n = '0;
        if (eg != 2'b00) begin
            sel = eg[1];
            check_eq("mem_we", {31'b0, mem_we}, {31'b0, sel ? we1 : we0});
            check_eq("mem_addr", mem_addr, sel ? addr1 : addr0);
            if (sel ? we1 : we0)
                check_eq("mem_wdata", mem_wdata, sel ? wdata1 : wdata0);
            else begin
                n.rv   = sel ? 2'b10 : 2'b01;
                n.data = init_val(sel ? addr1[7:0] : addr0[7:0]);
            end
        end else begin
            check_eq("mem_we_idle", {31'b0, mem_we}, 32'd0);
        end
        sb.push_back(n);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(8'(i));
        wdata0 = 32'hAAAA_5555;
        wdata1 = 32'h0000_0000;
        reset  = 1'b1;
        drive(1, 0, 0, 8'h10, 1, 0, 0, 8'h20);
        @(negedge clk);

        // Reset overrides requests
        repeat (3) tick(2'b00);
        reset = 1'b0;

        // Contention, no lock: strict alternation starting at requester 0
        for (int i = 0; i < 6; i++) tick((i % 2 == 0) ? 2'b01 : 2'b10);
        drive(0, 0, 0, 8'h10, 0, 0, 0, 8'h20);
        tick(2'b00);

        // Single read at 0x10, data 0x00FF next cycle
        drive(1, 0, 0, 8'h10, 0, 0, 0, 8'h20);
        tick(2'b01);
        drive(0, 0, 0, 8'h10, 0, 0, 0, 8'h20);
        tick(2'b00);

        // Write by requester 1: no rvalid afterwards
        wdata1 = 32'h0000_01FE;
        drive(0, 0, 0, 8'h10, 1, 0, 1, 8'h08);
        tick(2'b10);
        drive(0, 0, 0, 8'h10, 0, 0, 0, 8'h20);
        tick(2'b00);

        // Bring prio to 1, then lock limit of 4 with requester 0 waiting
        drive(1, 0, 0, 8'h14, 0, 0, 0, 8'h24);
        tick(2'b01);
        drive(1, 0, 0, 8'h14, 1, 1, 0, 8'h24);
        repeat (4) tick(2'b10);
        tick(2'b01);
        repeat (4) tick(2'b10);
        tick(2'b01);

        // Owner drops req while locked: lock ends, requester 0 served
        drive(0, 0, 0, 8'h14, 1, 1, 0, 8'h24);
        tick(2'b10);
        drive(1, 0, 0, 8'h14, 0, 0, 0, 8'h24);
        tick(2'b01);

        // Reset mid-read while locked: rvalid suppressed, no lock state survives
        drive(0, 0, 0, 8'h14, 1, 1, 0, 8'h24);
        tick(2'b10);
        tick(2'b10);
        reset = 1'b1;
        tick(2'b00);
        tick(2'b00);
        reset = 1'b0;
        drive(1, 0, 0, 8'h10, 1, 1, 0, 8'h20);
        tick(2'b01);
        repeat (4) tick(2'b10);
        tick(2'b01);
        drive(0, 0, 0, 8'h10, 0, 0, 0, 8'h20);
        tick(2'b00);
        tick(2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one single-port synchronous data memory between two requesters: requester 0 is the cpu data port, requester 1 is the program loader/debug port.
- Issues at most one memory access per cycle. Fairness is round-robin.
- A requester can lock the memory for back-to-back bursts. The lock is bounded by a consecutive-grant limit.
- Read data returns one cycle after grant, matching the memory's 1-cycle read latency.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_LOCK, 8, maximum consecutive grants to one locked requester before forced release (>=1)
- CW, 4, width of lock counter; must satisfy 2^CW > MAX_LOCK

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, held until granted
- lock0 / lock1  in  1  request exclusive back-to-back grants; sampled with req
- addr0 / addr1  in  AW  access address
- wdata0 / wdata1  in  DW  write data
- we0 / we1  in  1  1 = write, 0 = read
- gnt0 / gnt1  out  1  combinational; access accepted this cycle
- rvalid0 / rvalid1  out  1  registered; read data valid this cycle
- rdata  out  DW  = mem_rdata; qualified by rvalid0/rvalid1
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- State registers:
  - prio (1 bit): requester that wins a tie.
  - lock_act (1 bit), lock_own (1 bit).
  - lock_cnt (CW bits).
  - rv (2 bits): registered rvalid1/rvalid0.
- Reset, while reset=1: prio=0, lock_act=0, lock_own=0, lock_cnt=0, rv=0. gnt0 = gnt1 = mem_en = mem_we = 0. rvalid0 = rvalid1 = 0. Reset overrides all requests.
- Grant selection, combinational, at most one gnt per cycle:
  1. If lock_act and req[lock_own]: grant lock_own.
  2. Else if exactly one req: grant it.
  3. Else if both req: grant prio.
  4. Else: no grant.
- On a grant to requester g:
  - mem_en=1, mem_we=we_g, mem_addr=addr_g, mem_wdata=wdata_g.
  - With no grant: mem_en=0 and mem_we=0; mem_addr/mem_wdata are don't-care.
- prio update on every grant: prio <= ~g. With no grant, prio holds.
- Lock FSM, states UNLOCKED / LOCKED:
  - UNLOCKED -> LOCKED: grant to g with lock_g=1. Set lock_own<=g, lock_cnt<=1.
  - LOCKED, grant to lock_own with lock_own's lock=1 and lock_cnt<MAX_LOCK: stay; lock_cnt<=lock_cnt+1.
  - LOCKED -> UNLOCKED, any of:
    - owner's req=0;
    - owner's lock=0 at its grant (that grant is still issued);
    - owner's grant makes lock_cnt reach MAX_LOCK.
    - On exit: lock_cnt<=0.
  - Forced release: on the cycle after lock_cnt reaches MAX_LOCK, if the other requester is requesting it wins, because prio already points to it.
  - Re-lock: the released owner may re-lock on its next grant.
- Read return: a granted read sets rv[g]<=1 for exactly one cycle. A write or no grant clears rv. Writes never produce rvalid.
- Back-to-back reads: one grant per cycle gives one rvalid per cycle. rvalid for the access granted in cycle n appears in cycle n+1.
- Reset mid-read: rvalid due the next cycle is suppressed. No state survives reset.
- Requests whose req drops before grant are simply dropped; there is no queueing.
- MAX_LOCK=1: lock grants one access and releases; behaviour is identical to plain round-robin.

Test Plan:
- Reset: hold reset with req0=req1=1 -> gnt0=gnt1=0, mem_en=0. Release -> first cycle gnt0=1 (prio=0).
- Single read: req0, addr0=0x10, we0=0; memory returns 0x00FF -> gnt0 and mem_en same cycle, mem_addr=0x10; next cycle rvalid0=1, rdata=0x00FF, rvalid1=0.
- Contention: req0=req1=1 held for 6 cycles, no lock -> grants 0,1,0,1,0,1; rvalid alternates one cycle behind.
- Write: req1, we1=1, addr1=0x8, wdata1=0x01FE -> gnt1, mem_we=1, mem_wdata=0x01FE; next cycle rvalid0=rvalid1=0.
- Lock limit, MAX_LOCK=4: req1+lock1 held, req0 held -> gnt1 for 4 consecutive cycles, then gnt0, then gnt1 re-locks.
- Reset mid-op: read granted in cycle n, reset=1 in cycle n+1 -> rvalid0=0 in n+1. After release, prio=0 and lock_cnt=0.
